// File: rtl/vga_line_sched_pkg.sv
// Shared types and constants for the VGA line fetch scheduler.
// Holds the FSM encoding, line lengths and SDRAM bus widths.
package vga_line_sched_pkg;

    localparam int LINE_W_640  = 640;
    localparam int LINE_W_1024 = 1024;

    localparam int SD_ADDR_W  = 22;
    localparam int SD_DATA_W  = 16;
    localparam int SD_LEN_W   = 8;
    localparam int LINE_NUM_W = 12;
    localparam int WORD_W     = 10;
    // One bit wider than WORD_W so the 1024 terminal count fits.
    localparam int PTR_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_CMD,
        S_V_DATA,
        S_C_CMD,
        S_C_RD,
        S_C_DONE
    } state_t;

    function automatic logic [PTR_W-1:0] line_words(input logic mode_big);
        return mode_big ? PTR_W'(LINE_W_1024) : PTR_W'(LINE_W_640);
    endfunction

endpackage

// File: rtl/vga_req_sync.sv
// Two-flop synchronizer for the VGA line request plus rising-edge detect.
// Ports: clk, rst (sync, active high), i_req (async level), o_rise (pulse).
module vga_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    output logic o_rise
);

    // [0],[1] form the synchronizer; [2] is the history bit for the edge.
    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_req};
        end
    end

    assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/vga_line_sched.sv
// Sequences SDRAM burst reads of VGA display lines into line buffer A/B
// and interleaves single-word CPU accesses on the shared SDRAM port.
// Ports: sys_clk/sys_rst; VGA request (vga_mode, line_req, line_a_b,
// line_addr); line buffer write (lb_we_a/b, lb_waddr, lb_wdata);
// SDRAM command/data (mem_*); CPU access (cpu_*); status
// (fetch_busy, overrun).
module vga_line_sched
    import vga_line_sched_pkg::*;
#(
    parameter int BURST_LEN = 128,
    parameter int CPU_SLOTS = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [1:0]            vga_mode,
    input  logic                  line_req,
    input  logic                  line_a_b,
    input  logic [LINE_NUM_W-1:0] line_addr,
    output logic                  lb_we_a,
    output logic                  lb_we_b,
    output logic [WORD_W-1:0]     lb_waddr,
    output logic [SD_DATA_W-1:0]  lb_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [SD_ADDR_W-1:0]  mem_addr,
    output logic [SD_LEN_W-1:0]   mem_len,
    output logic [SD_DATA_W-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [SD_DATA_W-1:0]  mem_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [SD_ADDR_W-1:0]  cpu_addr,
    input  logic [SD_DATA_W-1:0]  cpu_wdata,
    output logic [SD_DATA_W-1:0]  cpu_rdata,
    output logic                  cpu_ack,
    output logic                  fetch_busy,
    output logic                  overrun
);

    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam int SLOT_W = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);

    localparam logic [BCNT_W-1:0]   BCNT_END = BCNT_W'(BURST_LEN);
    localparam logic [SLOT_W-1:0]   SLOT_MAX = SLOT_W'(CPU_SLOTS);
    localparam logic [SD_LEN_W-1:0] VLEN     = SD_LEN_W'(BURST_LEN - 1);

    state_t                  r_state;

    logic                    r_pend_v;
    logic                    r_pend_ab;
    logic [LINE_NUM_W-1:0]   r_pend_line;
    logic                    r_pend_big;

    logic                    r_ab;
    logic [LINE_NUM_W-1:0]   r_line;
    logic                    r_big;
    logic [PTR_W-1:0]        r_ptr;
    logic [BCNT_W-1:0]       r_bcnt;
    logic [SLOT_W-1:0]       r_slots;

    logic                    r_lb_we_a;
    logic                    r_lb_we_b;
    logic [WORD_W-1:0]       r_lb_waddr;
    logic [SD_DATA_W-1:0]    r_lb_wdata;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [SD_ADDR_W-1:0]    r_mem_addr;
    logic [SD_LEN_W-1:0]     r_mem_len;
    logic [SD_DATA_W-1:0]    r_mem_wdata;
    logic [SD_DATA_W-1:0]    r_cpu_rdata;
    logic                    r_cpu_ack;
    logic                    r_busy;
    logic                    r_overrun;

    logic                    w_rise;
    logic                    w_take;
    logic [PTR_W-1:0]        w_count;
    logic [SD_ADDR_W-1:0]    w_vaddr;
    logic                    w_unused_mode;

    vga_req_sync u_sync (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_req  (line_req),
        .o_rise (w_rise)
    );

    // Only the wide-line bit of the mode selects behaviour here.
    assign w_unused_mode = vga_mode[0];

    assign w_take  = (r_state == S_IDLE) && r_pend_v;
    assign w_count = line_words(r_big);
    assign w_vaddr = {r_line, r_ptr[WORD_W-1:0]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_pend_v    <= 1'b0;
            r_pend_ab   <= 1'b0;
            r_pend_line <= '0;
            r_pend_big  <= 1'b0;
            r_ab        <= 1'b0;
            r_line      <= '0;
            r_big       <= 1'b0;
            r_ptr       <= '0;
            r_bcnt      <= '0;
            r_slots     <= '0;
            r_lb_we_a   <= 1'b0;
            r_lb_we_b   <= 1'b0;
            r_lb_waddr  <= '0;
            r_lb_wdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_len   <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_lb_we_a <= 1'b0;
            r_lb_we_b <= 1'b0;
            r_cpu_ack <= 1'b0;

            // A slot being drained this cycle can accept the new edge.
            if (w_rise) begin
                if (r_pend_v && !w_take) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend_v    <= 1'b1;
                    r_pend_ab   <= line_a_b;
                    r_pend_line <= line_addr;
                    r_pend_big  <= vga_mode[1];
                end
            end else if (w_take) begin
                r_pend_v <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (r_pend_v) begin
                        r_ab       <= r_pend_ab;
                        r_line     <= r_pend_line;
                        r_big      <= r_pend_big;
                        r_ptr      <= '0;
                        r_slots    <= '0;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_pend_line, WORD_W'(0)};
                        r_mem_len  <= VLEN;
                        r_state    <= S_V_CMD;
                    end else if (cpu_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= cpu_we;
                        r_mem_addr  <= cpu_addr;
                        r_mem_len   <= '0;
                        r_mem_wdata <= cpu_wdata;
                        r_state     <= S_C_CMD;
                    end
                end
                S_V_CMD: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_bcnt    <= '0;
                        r_state   <= S_V_DATA;
                    end
                end
                S_V_DATA: begin
                    // Decide one cycle after the last word so the final
                    // buffer write is still covered by fetch_busy.
                    if (r_bcnt == BCNT_END) begin
                        if (r_ptr == w_count) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (cpu_req && (r_slots < SLOT_MAX)) begin
                            r_slots     <= r_slots + SLOT_W'(1);
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= cpu_we;
                            r_mem_addr  <= cpu_addr;
                            r_mem_len   <= '0;
                            r_mem_wdata <= cpu_wdata;
                            r_state     <= S_C_CMD;
                        end else begin
                            r_slots    <= '0;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_vaddr;
                            r_mem_len  <= VLEN;
                            r_state    <= S_V_CMD;
                        end
                    end else if (mem_rvalid) begin
                        r_lb_we_a  <= ~r_ab;
                        r_lb_we_b  <= r_ab;
                        r_lb_waddr <= r_ptr[WORD_W-1:0];
                        r_lb_wdata <= mem_rdata;
                        r_ptr      <= r_ptr + PTR_W'(1);
                        r_bcnt     <= r_bcnt + BCNT_W'(1);
                    end
                end
                S_C_CMD: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_cpu_ack <= 1'b1;
                            r_state   <= S_C_DONE;
                        end else begin
                            r_state <= S_C_RD;
                        end
                    end
                end
                S_C_RD: begin
                    if (mem_rvalid) begin
                        r_cpu_rdata <= mem_rdata;
                        r_cpu_ack   <= 1'b1;
                        r_state     <= S_C_DONE;
                    end
                end
                S_C_DONE: begin
                    if (r_busy) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_vaddr;
                        r_mem_len  <= VLEN;
                        r_state    <= S_V_CMD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lb_we_a    = r_lb_we_a;
    assign lb_we_b    = r_lb_we_b;
    assign lb_waddr   = r_lb_waddr;
    assign lb_wdata   = r_lb_wdata;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_len    = r_mem_len;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign fetch_busy = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_vga_line_sched.sv
// Scoreboard bench for vga_line_sched: SDRAM model, line-buffer monitor,
// and one task per scenario.
module tb_vga_line_sched;

    typedef struct {
        logic        ab;
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [21:0] a;
        logic [7:0]  len;
        logic        we;
        logic [15:0] wd;
    } cmd_t;

    logic        sys_clk;
    logic        sys_rst;
    logic [1:0]  vga_mode;
    logic        line_req;
    logic        line_a_b;
    logic [11:0] line_addr;
    logic        lb_we_a;
    logic        lb_we_b;
    logic [9:0]  lb_waddr;
    logic [15:0] lb_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_len;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        fetch_busy;
    logic        overrun;

    int vecs;
    int errs;
    int ack_cnt;

    wr_t  wr_q[$];
    cmd_t cmd_q[$];

    vga_line_sched dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .vga_mode   (vga_mode),
        .line_req   (line_req),
        .line_a_b   (line_a_b),
        .line_addr  (line_addr),
        .lb_we_a    (lb_we_a),
        .lb_we_b    (lb_we_b),
        .lb_waddr   (lb_waddr),
        .lb_wdata   (lb_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .fetch_busy (fetch_busy),
        .overrun    (overrun)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] md(input logic [21:0] a);
        return a[15:0] ^ {4'h0, a[21:10]} ^ 16'h3C5A;
    endfunction

    // SDRAM model: ack one cycle after a request, then one word per cycle.
    initial begin : mem_model
        int          mst;
        int          idx;
        logic [21:0] ca;
        logic [7:0]  cl;
        cmd_t        e;
        mst = 0;
        idx = 0;
        ca = '0;
        cl = '0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge sys_clk);
            mem_ack = 1'b0;
            mem_rvalid = 1'b0;
            if (sys_rst) begin
                mst = 0;
            end else if (mst == 0) begin
                if (mem_req === 1'b1) begin
                    vecs++;
                    if (cmd_q.size() == 0) begin
                        errs++;
                        $display("FAIL mem_cmd_unexpected: got addr=%h len=%0d we=%b, expected no command",
                                 mem_addr, mem_len, mem_we);
                    end else begin
                        e = cmd_q.pop_front();
                        if ({mem_addr, mem_len, mem_we} !== {e.a, e.len, e.we} ||
                            (e.we && mem_wdata !== e.wd)) begin
                            errs++;
                            $display("FAIL mem_cmd: got addr=%h len=%0d we=%b wd=%h, expected addr=%h len=%0d we=%b wd=%h",
                                     mem_addr, mem_len, mem_we, mem_wdata, e.a, e.len, e.we, e.wd);
                        end
                    end
                    ca = mem_addr;
                    cl = mem_len;
                    idx = 0;
                    mem_ack = 1'b1;
                    mst = mem_we ? 0 : 1;
                end
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata = md(ca + 22'(idx));
                idx++;
                if (idx > int'(cl)) mst = 0;
            end
        end
    end

    // Line buffer monitor: every write is popped against the scoreboard.
    initial begin : lb_monitor
        wr_t e;
        forever begin
            @(negedge sys_clk);
            if (lb_we_a === 1'b1 || lb_we_b === 1'b1) begin
                vecs++;
                if (wr_q.size() == 0) begin
                    errs++;
                    $display("FAIL lb_unexpected: got we_a=%b we_b=%b addr=%0d, expected no write",
                             lb_we_a, lb_we_b, lb_waddr);
                end else begin
                    e = wr_q.pop_front();
                    if ({lb_we_a, lb_we_b, lb_waddr, lb_wdata, fetch_busy} !==
                        {~e.ab, e.ab, e.a, e.d, 1'b1}) begin
                        errs++;
                        $display("FAIL lb_write: got we_a=%b we_b=%b addr=%0d data=%h busy=%b, expected we_a=%b we_b=%b addr=%0d data=%h busy=1",
                                 lb_we_a, lb_we_b, lb_waddr, lb_wdata, fetch_busy,
                                 ~e.ab, e.ab, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin : ack_monitor
        ack_cnt = 0;
        forever begin
            @(negedge sys_clk);
            if (cpu_ack === 1'b1) ack_cnt++;
        end
    end

    task automatic push_line(input logic ab, input logic [11:0] line,
                             input logic big, input logic with_cpu,
                             input cmd_t cpu_c);
        int   n;
        wr_t  w;
        cmd_t c;
        n = big ? 1024 : 640;
        for (int i = 0; i < n; i++) begin
            w.ab = ab;
            w.a  = 10'(i);
            w.d  = md({line, 10'(i)});
            wr_q.push_back(w);
        end
        for (int b = 0; b < n; b += 128) begin
            c.a   = {line, 10'(b)};
            c.len = 8'd127;
            c.we  = 1'b0;
            c.wd  = '0;
            cmd_q.push_back(c);
            if (with_cpu && b == 0) cmd_q.push_back(cpu_c);
        end
    endtask

    task automatic req_line(input logic ab, input logic [11:0] line,
                            input logic [1:0] mode);
        @(negedge sys_clk);
        line_a_b  = ab;
        line_addr = line;
        vga_mode  = mode;
        line_req  = 1'b1;
        repeat (4) @(negedge sys_clk);
        line_req = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge sys_clk);
            if (wr_q.size() == 0 && cmd_q.size() == 0 &&
                fetch_busy === 1'b0 && mem_req === 1'b0) begin
                ok = 1;
                break;
            end
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL %s_done: got writes_left=%0d cmds_left=%0d busy=%b, expected 0 0 0",
                     name, wr_q.size(), cmd_q.size(), fetch_busy);
        end
    endtask

    task automatic wait_ack(input string name, input logic [15:0] exp_d,
                            input logic chk_d);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (cpu_ack === 1'b1) begin
                ok = 1;
                break;
            end
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL %s_ack: got no cpu_ack, expected one", name);
        end else if (chk_d && cpu_rdata !== exp_d) begin
            errs++;
            $display("FAIL %s_rdata: got %h, expected %h", name, cpu_rdata, exp_d);
        end
        cpu_req = 1'b0;
    endtask

    task automatic check_zero(input string name);
        vecs++;
        if ({lb_we_a, lb_we_b, lb_waddr, lb_wdata, mem_req, mem_we, mem_addr,
             mem_len, mem_wdata, cpu_rdata, cpu_ack, fetch_busy, overrun} !== '0) begin
            errs++;
            $display("FAIL %s_outputs: got we=%b%b req=%b addr=%h len=%0d busy=%b ovr=%b ack=%b rd=%h, expected all 0",
                     name, lb_we_a, lb_we_b, mem_req, mem_addr, mem_len,
                     fetch_busy, overrun, cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        vga_mode  = 2'b00;
        line_req  = 1'b0;
        line_a_b  = 1'b0;
        line_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge sys_clk);
        check_zero("reset");
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_mode0_a();
        cmd_t nc;
        int   k;
        nc = '{default: '0};
        push_line(1'b0, 12'h005, 1'b0, 1'b0, nc);
        @(negedge sys_clk);
        line_a_b  = 1'b0;
        line_addr = 12'h005;
        vga_mode  = 2'b00;
        line_req  = 1'b1;
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (fetch_busy !== 1'b1 && k < 20);
        vecs++;
        if (k !== 4) begin
            errs++;
            $display("FAIL m0_latency: got busy after %0d cycles, expected 4", k);
        end
        line_req = 1'b0;
        wait_idle("m0");
        vecs++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL m0_overrun: got %b, expected 0", overrun);
        end
    endtask

    task automatic test_mode2_b();
        cmd_t nc;
        nc = '{default: '0};
        push_line(1'b1, 12'hFFF, 1'b1, 1'b0, nc);
        req_line(1'b1, 12'hFFF, 2'b10);
        wait_idle("m2");
    endtask

    task automatic test_cpu_idle_write();
        cmd_t c;
        int   a0;
        c.a   = 22'h02AAAA;
        c.len = 8'd0;
        c.we  = 1'b1;
        c.wd  = 16'hBEEF;
        cmd_q.push_back(c);
        a0 = ack_cnt;
        @(negedge sys_clk);
        cpu_we    = 1'b1;
        cpu_addr  = c.a;
        cpu_wdata = c.wd;
        cpu_req   = 1'b1;
        wait_ack("cpu_wr", 16'h0, 1'b0);
        @(negedge sys_clk);
        vecs++;
        if (cpu_ack !== 1'b0 || ack_cnt - a0 !== 1) begin
            errs++;
            $display("FAIL cpu_wr_pulse: got ack=%b count=%0d, expected 0 1",
                     cpu_ack, ack_cnt - a0);
        end
        wait_idle("cpu_wr");
    endtask

    task automatic test_cpu_between();
        cmd_t c;
        int   a0;
        c.a   = 22'h123456;
        c.len = 8'd0;
        c.we  = 1'b0;
        c.wd  = '0;
        push_line(1'b0, 12'h010, 1'b0, 1'b1, c);
        a0 = ack_cnt;
        req_line(1'b0, 12'h010, 2'b00);
        cpu_we   = 1'b0;
        cpu_addr = c.a;
        cpu_req  = 1'b1;
        wait_ack("cpu_mid", md(c.a), 1'b1);
        wait_idle("cpu_mid");
        vecs++;
        if (ack_cnt - a0 !== 1) begin
            errs++;
            $display("FAIL cpu_mid_count: got %0d acks, expected 1", ack_cnt - a0);
        end
    endtask

    task automatic test_overrun();
        cmd_t nc;
        nc = '{default: '0};
        push_line(1'b0, 12'h020, 1'b0, 1'b0, nc);
        push_line(1'b1, 12'h021, 1'b0, 1'b0, nc);
        req_line(1'b0, 12'h020, 2'b00);
        repeat (20) @(negedge sys_clk);
        req_line(1'b1, 12'h021, 2'b00);
        vecs++;
        if (overrun !== 1'b0) begin
            errs++;
            $display("FAIL ovr_early: got %b, expected 0", overrun);
        end
        req_line(1'b0, 12'h022, 2'b10);
        vecs++;
        if (overrun !== 1'b1) begin
            errs++;
            $display("FAIL ovr_set: got %b, expected 1", overrun);
        end
        wait_idle("ovr");
        repeat (10) @(negedge sys_clk);
        vecs++;
        if (overrun !== 1'b1) begin
            errs++;
            $display("FAIL ovr_sticky: got %b, expected 1", overrun);
        end
    endtask

    task automatic test_vga_cpu_same();
        cmd_t c;
        c.a   = 22'h0ABCDE;
        c.len = 8'd0;
        c.we  = 1'b0;
        c.wd  = '0;
        push_line(1'b0, 12'h030, 1'b0, 1'b1, c);
        @(negedge sys_clk);
        line_a_b  = 1'b0;
        line_addr = 12'h030;
        vga_mode  = 2'b00;
        line_req  = 1'b1;
        repeat (3) @(negedge sys_clk);
        cpu_we   = 1'b0;
        cpu_addr = c.a;
        cpu_req  = 1'b1;
        @(negedge sys_clk);
        vecs++;
        if (fetch_busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 22'h00C000) begin
            errs++;
            $display("FAIL same_prio: got busy=%b we=%b addr=%h, expected 1 0 00c000",
                     fetch_busy, mem_we, mem_addr);
        end
        line_req = 1'b0;
        wait_ack("same", md(c.a), 1'b1);
        wait_idle("same");
    endtask

    task automatic test_reset_mid();
        cmd_t nc;
        int   k;
        nc = '{default: '0};
        push_line(1'b1, 12'h040, 1'b1, 1'b0, nc);
        req_line(1'b1, 12'h040, 2'b10);
        k = 0;
        while (wr_q.size() > 974 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_zero("rst_mid");
        wr_q.delete();
        cmd_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (30) @(negedge sys_clk);
        vecs++;
        if (fetch_busy !== 1'b0 || mem_req !== 1'b0) begin
            errs++;
            $display("FAIL rst_quiet: got busy=%b req=%b, expected 0 0",
                     fetch_busy, mem_req);
        end
        push_line(1'b0, 12'h041, 1'b1, 1'b0, nc);
        req_line(1'b0, 12'h041, 2'b10);
        wait_idle("rst_refetch");
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_mode0_a();
        test_mode2_b();
        test_cpu_idle_write();
        test_cpu_between();
        test_overrun();
        test_vga_cpu_same();
        test_reset_mid();
        repeat (5) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
